mpt_walker_arbiter: RTL and testbench

Shares the single MPT walker between up to `NUM_REQ` permission-check requesters, such as fetch, load/store and a DMA port. The block:
- grants one requester at a time using round-robin priority;
- builds an `mptw_transaction_t` carrying a fresh transaction ID;
- drives the walker through a valid/ready issue handshake and waits for the matching response;
- returns the result to the granted requester.

It sits between the requester ports and the walker and owns flush sequencing for the walker path.

---
 rtl/mpt_pkg.sv | 58 +++++
 rtl/mpt_rr_arbiter.sv | 37 +++
 rtl/mpt_walker_arbiter.sv | 131 +++++++++++++
 tb/tb_mpt_walker_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpt_pkg.sv
// Shared MPT walker types: access/fault encodings, MMPT CSR layout, walker
// transaction record and the walker-arbiter state enum.
package mpt_pkg;

  localparam int unsigned XLEN            = 64;
  localparam int unsigned MPTW_ID_W       = 12;
  localparam int unsigned MPT_ARB_MAX_REQ = 8;

  localparam logic [3:0] BARE_MODE    = 4'd0;
  localparam logic [3:0] SMMPT43_MODE = 4'd1;

  typedef enum logic [1:0] {
    ACCESS_NONE    = 2'd0,
    ACCESS_READ    = 2'd1,
    ACCESS_WRITE   = 2'd2,
    ACCESS_EXECUTE = 2'd3
  } mpt_access_e;

  typedef enum logic [2:0] {
    NO_ERROR        = 3'd0,
    RESERVED_BITS   = 3'd1,
    NOT_VALID_ENTRY = 3'd2,
    MISALIGNED_PPN  = 3'd3,
    LEVEL_OVERFLOW  = 3'd4
  } page_format_fault_e;

  typedef enum logic [1:0] {
    MPT_WALKING_IDLE = 2'd0,
    MPT_WALKING_DO   = 2'd1,
    MPT_WALKING_DONE = 2'd2
  } mpt_walking_e;

  typedef struct packed {
    logic [3:0]  MODE;
    logic [15:0] SDID;
    logic [43:0] PPN;
  } mmpt_reg_t;

  typedef struct packed {
    logic                   valid;
    logic [MPTW_ID_W-1:0]   id;
    logic [XLEN-1:0]        spa;
    mpt_access_e            access_type;
    mmpt_reg_t              mmpt;
    mpt_walking_e           walking;
    logic                   access_error;
    page_format_fault_e     format_error;
    logic [1:0]             level;
  } mptw_transaction_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DRAIN = 2'd3
  } mpt_arb_state_e;

endpackage

// File: rtl/mpt_rr_arbiter.sv
// Combinational round-robin picker: grants the first set request at or
// after ptr_i, wrapping back to index 0.
module mpt_rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  logic             hi_found, lo_found;
  logic [IDX_W-1:0] hi_idx, lo_idx;

  // Scan downward so the lowest qualifying index in each half wins.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        if (IDX_W'(i) >= ptr_i) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = IDX_W'(i);
        end
      end
    end
    gnt_idx_o = hi_found ? hi_idx : lo_idx;
    gnt_o     = (hi_found || lo_found) ? (NUM_REQ'(1) << gnt_idx_o) : '0;
  end

endmodule

// File: rtl/mpt_walker_arbiter.sv
// Shares the single MPT walker between NUM_REQ requesters: round-robin grant,
// one outstanding walk, id-matched response return and flush sequencing.
module mpt_walker_arbiter
  import mpt_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ID_W    = 12
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     flush_i,
  input  logic [NUM_REQ-1:0]                       req_valid_i,
  output logic [NUM_REQ-1:0]                       req_ready_o,
  input  logic [NUM_REQ-1:0][XLEN-1:0]             req_spa_i,
  input  logic [NUM_REQ-1:0][1:0]                  req_access_i,
  input  logic [NUM_REQ-1:0][$bits(mmpt_reg_t)-1:0] req_mmpt_i,
  output logic [NUM_REQ-1:0]                       rsp_valid_o,
  output logic                                     rsp_access_error_o,
  output logic [2:0]                               rsp_format_error_o,
  output logic                                     walk_req_valid_o,
  input  logic                                     walk_req_ready_i,
  output mptw_transaction_t                        walk_txn_o,
  input  logic                                     walk_rsp_valid_i,
  input  mptw_transaction_t                        walk_rsp_i
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  mpt_arb_state_e    state_q;
  logic [IDX_W-1:0]  rr_ptr_q, grant_q;
  logic [ID_W-1:0]   id_cnt_q;
  mptw_transaction_t walk_txn_q, walk_txn_d;
  logic              walk_req_valid_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic              rsp_access_error_q;
  logic [2:0]        rsp_format_error_q;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               grant_fire;
  mmpt_reg_t          sel_mmpt;
  logic               unused_rsp_bits;

  mpt_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i     (req_valid_i),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign grant_fire      = (state_q == ARB_IDLE) && !flush_i && (|req_valid_i);
  assign req_ready_o     = grant_fire ? gnt : '0;
  assign sel_mmpt        = mmpt_reg_t'(req_mmpt_i[gnt_idx]);
  assign unused_rsp_bits = ^walk_rsp_i;

  always_comb begin
    walk_txn_d              = '0;
    walk_txn_d.valid        = 1'b1;
    walk_txn_d.id           = MPTW_ID_W'(id_cnt_q);
    walk_txn_d.spa          = req_spa_i[gnt_idx];
    walk_txn_d.access_type  = mpt_access_e'(req_access_i[gnt_idx]);
    walk_txn_d.mmpt         = sel_mmpt;
    walk_txn_d.walking      = MPT_WALKING_DO;
    walk_txn_d.format_error = NO_ERROR;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q            <= ARB_IDLE;
      rr_ptr_q           <= '0;
      grant_q            <= '0;
      id_cnt_q           <= '0;
      walk_txn_q         <= '0;
      walk_req_valid_q   <= 1'b0;
      rsp_valid_q        <= '0;
      rsp_access_error_q <= 1'b0;
      rsp_format_error_q <= '0;
    end else begin
      rsp_valid_q        <= '0;
      rsp_access_error_q <= 1'b0;
      rsp_format_error_q <= '0;
      unique case (state_q)
        ARB_IDLE: begin
          if (grant_fire) begin
            walk_txn_q <= walk_txn_d;
            grant_q    <= gnt_idx;
            id_cnt_q   <= id_cnt_q + 1'b1;
            rr_ptr_q   <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            // Bare mode needs no walk: answer directly with no errors.
            if (sel_mmpt.MODE == BARE_MODE) begin
              rsp_valid_q <= gnt;
            end else begin
              walk_req_valid_q <= 1'b1;
              state_q          <= ARB_ISSUE;
            end
          end
        end
        ARB_ISSUE: begin
          if (flush_i) begin
            walk_req_valid_q <= 1'b0;
            state_q          <= ARB_IDLE;
          end else if (walk_req_ready_i) begin
            walk_req_valid_q <= 1'b0;
            state_q          <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          // A flush with no response still owes us one walker reply to absorb.
          if (flush_i) begin
            state_q <= walk_rsp_valid_i ? ARB_IDLE : ARB_DRAIN;
          end else if (walk_rsp_valid_i && (walk_rsp_i.id == walk_txn_q.id)) begin
            rsp_valid_q        <= NUM_REQ'(1) << grant_q;
            rsp_access_error_q <= walk_rsp_i.access_error;
            rsp_format_error_q <= walk_rsp_i.format_error;
            state_q            <= ARB_IDLE;
          end
        end
        ARB_DRAIN: begin
          if (walk_rsp_valid_i) state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign walk_req_valid_o   = walk_req_valid_q;
  assign walk_txn_o         = walk_txn_q;
  assign rsp_valid_o        = rsp_valid_q;
  assign rsp_access_error_o = rsp_access_error_q;
  assign rsp_format_error_o = rsp_format_error_q;

endmodule

// File: tb/tb_mpt_walker_arbiter.sv
// Directed bench for mpt_walker_arbiter: table of request/response rows plus
// hand-written flush, stale-id and id-wrap sequences.
module tb_mpt_walker_arbiter;
  import mpt_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst_i;
  logic                         flush_i;
  logic [2:0]                   req_valid_i;
  logic [2:0]                   req_ready_o;
  logic [2:0][XLEN-1:0]         req_spa_i;
  logic [2:0][1:0]              req_access_i;
  logic [2:0][63:0]             req_mmpt_i;
  logic [2:0]                   rsp_valid_o;
  logic                         rsp_access_error_o;
  logic [2:0]                   rsp_format_error_o;
  logic                         walk_req_valid_o;
  logic                         walk_req_ready_i;
  mptw_transaction_t            walk_txn_o;
  logic                         walk_rsp_valid_i;
  mptw_transaction_t            walk_rsp_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mpt_walker_arbiter #(.NUM_REQ(3), .ID_W(12)) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .flush_i            (flush_i),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_spa_i          (req_spa_i),
    .req_access_i       (req_access_i),
    .req_mmpt_i         (req_mmpt_i),
    .rsp_valid_o        (rsp_valid_o),
    .rsp_access_error_o (rsp_access_error_o),
    .rsp_format_error_o (rsp_format_error_o),
    .walk_req_valid_o   (walk_req_valid_o),
    .walk_req_ready_i   (walk_req_ready_i),
    .walk_txn_o         (walk_txn_o),
    .walk_rsp_valid_i   (walk_rsp_valid_i),
    .walk_rsp_i         (walk_rsp_i)
  );

  typedef struct {
    logic [2:0]  mask;
    logic [3:0]  mode;
    logic [2:0]  gnt;
    logic [11:0] id;
    int          stall;
    int          lat;
    logic [2:0]  fmt;
    logic        aerr;
  } row_t;

  row_t rows [8];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_payload(input int tag, input logic [3:0] mode);
    mmpt_reg_t m;
    for (int i = 0; i < 3; i++) begin
      req_spa_i[i]    = 64'h8000_0000 + (64'(tag) << 8) + (64'(i) << 4);
      req_access_i[i] = 2'(i + 1);
      m.MODE = mode;
      m.SDID = 16'(16'h0a0 + i);
      m.PPN  = 44'(44'h1000 + tag * 3 + i);
      req_mmpt_i[i] = m;
    end
  endtask

  function automatic mptw_transaction_t exp_txn(input int gidx, input logic [11:0] id);
    mptw_transaction_t e;
    e              = '0;
    e.valid        = 1'b1;
    e.id           = id;
    e.spa          = req_spa_i[gidx];
    e.access_type  = mpt_access_e'(req_access_i[gidx]);
    e.mmpt         = mmpt_reg_t'(req_mmpt_i[gidx]);
    e.walking      = MPT_WALKING_DO;
    e.format_error = NO_ERROR;
    return e;
  endfunction

  function automatic mptw_transaction_t mk_rsp(input logic [11:0] id, input logic [2:0] fmt, input logic aerr);
    mptw_transaction_t r;
    r              = '0;
    r.valid        = 1'b1;
    r.id           = id;
    r.walking      = MPT_WALKING_DONE;
    r.format_error = page_format_fault_e'(fmt);
    r.access_error = aerr;
    return r;
  endfunction

  task automatic run_row(input row_t r, input int tag);
    int gidx;
    mptw_transaction_t e;
    gidx = (r.gnt == 3'b001) ? 0 : (r.gnt == 3'b010) ? 1 : 2;
    @(negedge clk);
    set_payload(tag, r.mode);
    req_valid_i = r.mask;
    #1;
    check($sformatf("grant_t%0d", tag), req_ready_o, r.gnt);
    check($sformatf("issue_low_at_grant_t%0d", tag), walk_req_valid_o, 1'b0);
    e = exp_txn(gidx, r.id);
    @(negedge clk);
    req_valid_i = '0;
    if (r.mode == BARE_MODE) begin
      check($sformatf("bare_rsp_t%0d", tag), rsp_valid_o, r.gnt);
      check($sformatf("bare_err_t%0d", tag), {rsp_access_error_o, rsp_format_error_o}, 4'h0);
      check($sformatf("bare_no_issue_t%0d", tag), walk_req_valid_o, 1'b0);
      @(negedge clk);
      check($sformatf("bare_no_issue2_t%0d", tag), walk_req_valid_o, 1'b0);
      check($sformatf("bare_rsp_pulse_t%0d", tag), rsp_valid_o, 3'b000);
    end else begin
      check($sformatf("issue_t%0d", tag), walk_req_valid_o, 1'b1);
      check($sformatf("txn_t%0d", tag), walk_txn_o, e);
      for (int s = 0; s < r.stall; s++) begin
        @(negedge clk);
        check($sformatf("stall_valid_t%0d", tag), walk_req_valid_o, 1'b1);
        check($sformatf("stall_txn_t%0d", tag), walk_txn_o, e);
      end
      walk_req_ready_i = 1'b1;
      @(negedge clk);
      walk_req_ready_i = 1'b0;
      check($sformatf("issue_drop_t%0d", tag), walk_req_valid_o, 1'b0);
      repeat (r.lat - 1) @(negedge clk);
      walk_rsp_valid_i = 1'b1;
      walk_rsp_i = mk_rsp(r.id, r.fmt, r.aerr);
      #1;
      check($sformatf("rsp_early_t%0d", tag), rsp_valid_o, 3'b000);
      @(negedge clk);
      walk_rsp_valid_i = 1'b0;
      check($sformatf("rsp_t%0d", tag), rsp_valid_o, r.gnt);
      check($sformatf("rsp_fmt_t%0d", tag), rsp_format_error_o, r.fmt);
      check($sformatf("rsp_aerr_t%0d", tag), rsp_access_error_o, r.aerr);
    end
  endtask

  initial begin
    int bad;
    rst_i = 1'b1; flush_i = 1'b0; req_valid_i = '0; walk_req_ready_i = 1'b0;
    walk_rsp_valid_i = 1'b0; walk_rsp_i = '0;
    set_payload(0, SMMPT43_MODE);

    rows[0] = '{3'b111, SMMPT43_MODE, 3'b001, 12'd0, 0, 4, 3'd0, 1'b0};
    rows[1] = '{3'b111, SMMPT43_MODE, 3'b010, 12'd1, 0, 4, 3'd0, 1'b0};
    rows[2] = '{3'b111, SMMPT43_MODE, 3'b100, 12'd2, 0, 4, 3'd0, 1'b0};
    rows[3] = '{3'b111, SMMPT43_MODE, 3'b001, 12'd3, 0, 4, 3'd0, 1'b0};
    rows[4] = '{3'b010, BARE_MODE,    3'b010, 12'd4, 0, 0, 3'd0, 1'b0};
    rows[5] = '{3'b010, SMMPT43_MODE, 3'b010, 12'd5, 5, 2, 3'd2, 1'b1};
    rows[6] = '{3'b011, SMMPT43_MODE, 3'b001, 12'd6, 1, 3, 3'd0, 1'b0};
    rows[7] = '{3'b101, SMMPT43_MODE, 3'b100, 12'd7, 0, 1, 3'd1, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_ready", req_ready_o, 3'b000);
    check("rst_rsp", rsp_valid_o, 3'b000);
    check("rst_issue", walk_req_valid_o, 1'b0);
    check("rst_txn", walk_txn_o, 256'h0);
    check("rst_err", {rsp_access_error_o, rsp_format_error_o}, 4'h0);
    rst_i = 1'b0;
    @(negedge clk);
    check("post_rst_txn", walk_txn_o, 256'h0);

    for (int i = 0; i < 8; i++) run_row(rows[i], i + 1);

    // Flush blocks grant in idle, then aborts an issue (rr_ptr 0, next id 8).
    @(negedge clk);
    set_payload(20, SMMPT43_MODE);
    req_valid_i = 3'b001; flush_i = 1'b1;
    #1 check("flush_idle_no_grant", req_ready_o, 3'b000);
    @(negedge clk);
    flush_i = 1'b0;
    #1 check("grant_after_flush", req_ready_o, 3'b001);
    @(negedge clk);
    req_valid_i = '0;
    check("issue_before_flush", walk_req_valid_o, 1'b1);
    check("issue_id8", walk_txn_o.id, 12'd8);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_issue_drop", walk_req_valid_o, 1'b0);
    check("flush_issue_no_rsp", rsp_valid_o, 3'b000);

    // Flush in WAIT, drain absorbs the late response (rr_ptr 1, id 9).
    @(negedge clk);
    set_payload(21, SMMPT43_MODE);
    req_valid_i = 3'b100;
    #1 check("grant_drain_case", req_ready_o, 3'b100);
    @(negedge clk);
    req_valid_i = '0;
    check("issue_id9", walk_txn_o.id, 12'd9);
    walk_req_ready_i = 1'b1;
    @(negedge clk);
    walk_req_ready_i = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; req_valid_i = 3'b010;
    #1 check("drain_no_grant", req_ready_o, 3'b000);
    @(negedge clk);
    flush_i = 1'b1;
    #1 check("drain_no_grant2", req_ready_o, 3'b000);
    @(negedge clk);
    flush_i = 1'b0;
    walk_rsp_valid_i = 1'b1; walk_rsp_i = mk_rsp(12'd9, 3'd0, 1'b0);
    #1 check("drain_no_grant3", req_ready_o, 3'b000);
    @(negedge clk);
    walk_rsp_valid_i = 1'b0;
    check("drain_no_rsp", rsp_valid_o, 3'b000);
    #1 check("grant_after_drain", req_ready_o, 3'b010);

    // Flush together with the walker response (id 10, rr_ptr now 2).
    @(negedge clk);
    req_valid_i = '0;
    check("issue_id10", walk_txn_o.id, 12'd10);
    walk_req_ready_i = 1'b1;
    @(negedge clk);
    walk_req_ready_i = 1'b0;
    @(negedge clk);
    walk_rsp_valid_i = 1'b1; walk_rsp_i = mk_rsp(12'd10, 3'd2, 1'b1); flush_i = 1'b1;
    @(negedge clk);
    walk_rsp_valid_i = 1'b0; flush_i = 1'b0;
    check("coincident_no_rsp", rsp_valid_o, 3'b000);
    req_valid_i = 3'b001;
    #1 check("coincident_idle", req_ready_o, 3'b001);

    // Stale id is ignored, matching id completes (id 11, rr_ptr now 1).
    @(negedge clk);
    req_valid_i = '0;
    check("issue_id11", walk_txn_o.id, 12'd11);
    walk_req_ready_i = 1'b1;
    @(negedge clk);
    walk_req_ready_i = 1'b0;
    @(negedge clk);
    walk_rsp_valid_i = 1'b1; walk_rsp_i = mk_rsp(12'd10, 3'd2, 1'b1);
    @(negedge clk);
    walk_rsp_valid_i = 1'b0;
    check("stale_no_rsp", rsp_valid_o, 3'b000);
    @(negedge clk);
    walk_rsp_valid_i = 1'b1; walk_rsp_i = mk_rsp(12'd11, 3'd0, 1'b0);
    @(negedge clk);
    walk_rsp_valid_i = 1'b0;
    check("match_rsp", rsp_valid_o, 3'b001);
    check("match_err", {rsp_access_error_o, rsp_format_error_o}, 4'h0);

    // Burn ids 12..4094 with back-to-back bare grants, then cross the wrap.
    set_payload(30, BARE_MODE);
    bad = 0;
    for (int k = 0; k < 4083; k++) begin
      @(negedge clk);
      req_valid_i = 3'b010;
      #1 if (req_ready_o !== 3'b010) bad++;
      @(negedge clk);
      req_valid_i = '0;
      if (rsp_valid_o !== 3'b010 || walk_req_valid_o !== 1'b0) bad++;
    end
    check("bare_burst_errors", 32'(bad), 32'd0);
    run_row('{3'b010, SMMPT43_MODE, 3'b010, 12'd4095, 0, 2, 3'd0, 1'b0}, 40);
    run_row('{3'b001, SMMPT43_MODE, 3'b001, 12'd0,    2, 3, 3'd4, 1'b1}, 41);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
